// File: rtl/dino_frame_scheduler.sv
// Per-frame game-update sequencer for the DINO VGA renderer: detects vertical blank, then runs
// jump physics, obstacle scroll, collision and commit. Optional macro: DINO_SPEEDUP_EN.
module dino_frame_scheduler #(
    parameter int V_ACTIVE     = 480,
    parameter int GROUND_Y     = 200,
    parameter int DINO_X       = 80,
    parameter int SPRITE_W     = 8,
    parameter int JUMP_V0      = 12,
    parameter int GRAVITY      = 1,
    parameter int OBST_START_X = 640,
    parameter int OBST_SPEED   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  counter_x,
    input  logic [9:0]  counter_y,
    input  logic        jump_btn,
    output logic        frame_tick,
    output logic [8:0]  dino_y,
    output logic [9:0]  obst_x,
    output logic [15:0] score,
    output logic [1:0]  game_state,
    output logic        collision
);

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_PHYS   = 3'd1,
        SEQ_OBST   = 3'd2,
        SEQ_COLL   = 3'd3,
        SEQ_COMMIT = 3'd4
    } seq_e;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_RUN   = 2'd1,
        ST_OVER  = 2'd2
    } game_e;

    localparam logic [9:0]         V_ACT    = 10'(V_ACTIVE);
    localparam logic [8:0]         GND_Y    = 9'(GROUND_Y);
    localparam logic signed [10:0] GND_Y_S  = 11'(GROUND_Y);
    localparam logic [9:0]         START_X  = 10'(OBST_START_X);
    localparam logic signed [5:0]  V0       = 6'(JUMP_V0);
    localparam logic signed [5:0]  GRAV     = 6'(GRAVITY);
    localparam logic [10:0]        HIT_X_HI = 11'(DINO_X + SPRITE_W);
    localparam logic [10:0]        HIT_X_LO = 11'(DINO_X);
    localparam logic [10:0]        SPR_W    = 11'(SPRITE_W);

    seq_e              seq_q, seq_d;
    logic              tick_q, tick_d;
    logic              jump_prev_q;
    logic              pending_q, pending_d;
    logic              air_q, air_d;
    logic signed [5:0] vel_q, vel_d;
    logic              move_q, move_d;

    // Shadow copy of the game, advanced step by step while the renderer still shows the old frame.
    logic [8:0]        y_sh_q, y_sh_d;
    logic [9:0]        x_sh_q, x_sh_d;
    logic [15:0]       score_sh_q, score_sh_d;
    game_e             state_sh_q, state_sh_d;
    logic              coll_sh_q, coll_sh_d;

    logic [8:0]        dino_y_q, dino_y_d;
    logic [9:0]        obst_x_q, obst_x_d;
    logic [15:0]       score_q, score_d;
    game_e             state_q, state_d;
    logic              coll_q, coll_d;

    logic              jump_edge;
    logic              hit;
    logic [9:0]        speed;
    logic signed [5:0] vel_use;
    logic signed [10:0] y_next;

`ifdef DINO_SPEEDUP_EN
    logic [16:0] speed_sum;

    always_comb begin
        speed_sum = 17'(OBST_SPEED) + 17'(score_sh_q >> 3);
        speed     = (speed_sum > 17'd15) ? 10'd15 : 10'(speed_sum);
    end
`else
    assign speed = 10'(OBST_SPEED);
`endif

    assign hit = ({1'b0, x_sh_q} < HIT_X_HI) &&
                 (({1'b0, x_sh_q} + SPR_W) > HIT_X_LO) &&
                 (({2'b00, y_sh_q} + SPR_W) > {2'b00, GND_Y});

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        seq_d      = seq_q;
        tick_d     = (counter_x == 10'd0) && (counter_y == V_ACT);
        jump_edge  = jump_btn & ~jump_prev_q;
        pending_d  = pending_q | jump_edge;
        air_d      = air_q;
        vel_d      = vel_q;
        move_d     = move_q;
        y_sh_d     = y_sh_q;
        x_sh_d     = x_sh_q;
        score_sh_d = score_sh_q;
        state_sh_d = state_sh_q;
        coll_sh_d  = coll_sh_q;
        dino_y_d   = dino_y_q;
        obst_x_d   = obst_x_q;
        score_d    = score_q;
        state_d    = state_q;
        coll_d     = coll_q;
        vel_use    = vel_q;
        y_next     = '0;

        unique case (seq_q)
            SEQ_IDLE: begin
                if (tick_q) seq_d = SEQ_PHYS;
            end
            SEQ_PHYS: begin
                seq_d     = SEQ_OBST;
                pending_d = jump_edge;  // an edge arriving now survives the clear
                move_d    = 1'b0;
                if (state_sh_q == ST_OVER) begin
                    if (pending_q) begin
                        y_sh_d     = GND_Y;
                        x_sh_d     = START_X;
                        score_sh_d = 16'd0;
                        coll_sh_d  = 1'b0;
                        air_d      = 1'b0;
                        vel_d      = '0;
                        state_sh_d = ST_RUN;
                    end
                end else if (state_sh_q == ST_RUN || pending_q) begin
                    state_sh_d = ST_RUN;
                    move_d     = 1'b1;
                    if (air_q || pending_q) begin
                        vel_use = air_q ? vel_q : V0;
                        y_next  = {2'b00, y_sh_q} - {{5{vel_use[5]}}, vel_use};
                        if (y_next >= GND_Y_S) begin
                            y_sh_d = GND_Y;
                            air_d  = 1'b0;
                            vel_d  = '0;
                        end else begin
                            y_sh_d = (y_next < 11'sd0) ? 9'd0 : y_next[8:0];
                            air_d  = 1'b1;
                            vel_d  = vel_use - GRAV;
                        end
                    end
                end
            end
            SEQ_OBST: begin
                seq_d = SEQ_COLL;
                if (move_q) begin
                    if (x_sh_q < speed) begin
                        x_sh_d = START_X;
                        if (score_sh_q != 16'hFFFF) score_sh_d = score_sh_q + 16'd1;
                    end else begin
                        x_sh_d = x_sh_q - speed;
                    end
                end
            end
            SEQ_COLL: begin
                seq_d = SEQ_COMMIT;
                if (move_q && hit) begin
                    coll_sh_d  = 1'b1;
                    state_sh_d = ST_OVER;
                end
            end
            SEQ_COMMIT: begin
                seq_d    = SEQ_IDLE;
                dino_y_d = y_sh_q;
                obst_x_d = x_sh_q;
                score_d  = score_sh_q;
                state_d  = state_sh_q;
                coll_d   = coll_sh_q;
            end
            default: seq_d = SEQ_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments and a reset sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seq_q       <= SEQ_IDLE;
            tick_q      <= 1'b0;
            jump_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            air_q       <= 1'b0;
            vel_q       <= '0;
            move_q      <= 1'b0;
            y_sh_q      <= GND_Y;
            x_sh_q      <= START_X;
            score_sh_q  <= 16'd0;
            state_sh_q  <= ST_READY;
            coll_sh_q   <= 1'b0;
            dino_y_q    <= GND_Y;
            obst_x_q    <= START_X;
            score_q     <= 16'd0;
            state_q     <= ST_READY;
            coll_q      <= 1'b0;
        end else begin
            seq_q       <= seq_d;
            tick_q      <= tick_d;
            jump_prev_q <= jump_btn;
            pending_q   <= pending_d;
            air_q       <= air_d;
            vel_q       <= vel_d;
            move_q      <= move_d;
            y_sh_q      <= y_sh_d;
            x_sh_q      <= x_sh_d;
            score_sh_q  <= score_sh_d;
            state_sh_q  <= state_sh_d;
            coll_sh_q   <= coll_sh_d;
            dino_y_q    <= dino_y_d;
            obst_x_q    <= obst_x_d;
            score_q     <= score_d;
            state_q     <= state_d;
            coll_q      <= coll_d;
        end
    end

    assign frame_tick = tick_q;
    assign dino_y     = dino_y_q;
    assign obst_x     = obst_x_q;
    assign score      = score_q;
    assign game_state = state_q;
    assign collision  = coll_q;

endmodule

// File: tb/tb_dino_frame_scheduler.sv
// Directed bench for dino_frame_scheduler: drives short synthetic frames around the (0,480)
// vertical-blank point and compares committed outputs against hand-computed trajectories.
module tb_dino_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  counter_x;
    logic [9:0]  counter_y;
    logic        jump_btn;
    logic        frame_tick;
    logic [8:0]  dino_y;
    logic [9:0]  obst_x;
    logic [15:0] score;
    logic [1:0]  game_state;
    logic        collision;

    int n_vec = 0;
    int n_err = 0;
    int tick_cycles;
    bit changed_early;

    // Dino top row for each frame of a jump started from the ground (v0=12, gravity=1).
    int jump_y [25] = '{188, 177, 167, 158, 150, 143, 137, 132, 128, 125, 123, 122, 122,
                        123, 125, 128, 132, 137, 143, 150, 158, 167, 177, 188, 200};

    always #20 clk = ~clk;

    dino_frame_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .jump_btn   (jump_btn),
        .frame_tick (frame_tick),
        .dino_y     (dino_y),
        .obst_x     (obst_x),
        .score      (score),
        .game_state (game_state),
        .collision  (collision)
    );

    function automatic logic [37:0] outs();
        return {dino_y, obst_x, score, game_state, collision};
    endfunction

    function automatic logic [37:0] exp_outs(input int y, input int x, input int s,
                                             input int g, input int c);
        return {9'(y), 10'(x), 16'(s), 2'(g), 1'(c)};
    endfunction

    // One synthetic frame. jump_mode: 0 none, 1 press during active video,
    // 2 press on the cycle the sequencer sits in its physics step.
    task automatic run_frame(input int jump_mode);
        logic [37:0] snap;
        snap          = outs();
        changed_early = 1'b0;
        tick_cycles   = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) tick_cycles++;
            if (outs() !== snap) changed_early = 1'b1;
            case (i)
                0, 1, 2, 3: begin
                    counter_x = 10'(100 + i * 37);
                    counter_y = 10'(20 + i * 113);
                    if (jump_mode == 1 && i == 0) jump_btn = 1'b1;
                end
                4: begin counter_x = 10'd0; counter_y = 10'd479; end
                5: begin counter_x = 10'd5; counter_y = 10'd480; end
                6: begin counter_x = 10'd0; counter_y = 10'd480; end
                8: begin
                    counter_x = 10'(i);
                    if (jump_mode == 2) jump_btn = 1'b1;
                end
                default: counter_x = 10'(i);
            endcase
        end
        @(negedge clk);
        if (frame_tick === 1'b1) tick_cycles++;
        jump_btn  = 1'b0;
        counter_x = 10'd0;
        counter_y = 10'd0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        jump_btn  = 1'b0;
        counter_x = 10'd0;
        counter_y = 10'd0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({frame_tick, outs()} !== {1'b0, exp_outs(200, 640, 0, 0, 0)}) begin
            n_err++;
            $display("FAIL reset_values: got tick=%0d y=%0d x=%0d s=%0d g=%0d c=%0d, want tick=0 y=200 x=640 s=0 g=0 c=0",
                     frame_tick, dino_y, obst_x, score, game_state, collision);
        end
        rst = 1'b1;
        run_frame(0);
        n_vec++;
        if (tick_cycles !== 1) begin
            n_err++;
            $display("FAIL reset_frame_tick: got %0d high cycles, want 1", tick_cycles);
        end
        n_vec++;
        if (changed_early !== 1'b0) begin
            n_err++;
            $display("FAIL reset_early_change: outputs moved before commit, want stable");
        end
        n_vec++;
        if (outs() !== exp_outs(200, 640, 0, 0, 0)) begin
            n_err++;
            $display("FAIL ready_commit: got y=%0d x=%0d s=%0d g=%0d c=%0d, want y=200 x=640 s=0 g=0 c=0",
                     dino_y, obst_x, score, game_state, collision);
        end
    endtask

    // Frames 1..26: jump from READY, full arc, then one grounded frame.
    task automatic test_jump();
        int bad = 0;
        for (int k = 1; k <= 26; k++) begin
            int ey;
            run_frame(k == 1 ? 1 : 0);
            ey = (k <= 25) ? jump_y[k-1] : 200;
            if (tick_cycles != 1 || changed_early) bad++;
            n_vec++;
            if (outs() !== exp_outs(ey, 640 - 4 * k, 0, 1, 0)) begin
                n_err++;
                $display("FAIL jump_frame_%0d: got y=%0d x=%0d s=%0d g=%0d c=%0d, want y=%0d x=%0d s=0 g=1 c=0",
                         k, dino_y, obst_x, score, game_state, collision, ey, 640 - 4 * k);
            end
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL jump_frame_timing: got %0d bad frames, want 0", bad);
        end
    endtask

    // Frames 27..161: scroll to wrap, jumping over the obstacle at frame 130.
    task automatic test_scroll();
        int bad = 0;
        for (int k = 27; k <= 161; k++) begin
            int ey, ex, es;
            run_frame(k == 130 ? 1 : 0);
            ey = (k >= 130 && k <= 154) ? jump_y[k-130] : 200;
            ex = (k <= 160) ? 640 - 4 * k : 640;
            es = (k == 161) ? 1 : 0;
            if (tick_cycles != 1 || changed_early) bad++;
            n_vec++;
            if (outs() !== exp_outs(ey, ex, es, 1, 0)) begin
                n_err++;
                $display("FAIL scroll_frame_%0d: got y=%0d x=%0d s=%0d g=%0d c=%0d, want y=%0d x=%0d s=%0d g=1 c=0",
                         k, dino_y, obst_x, score, game_state, collision, ey, ex, es);
            end
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL scroll_frame_timing: got %0d bad frames, want 0", bad);
        end
    endtask

    // Frames 162..304: grounded until hit at x=84, frozen, restart, then one plain frame.
    task automatic test_collision();
        for (int k = 162; k <= 304; k++) begin
            int ex, es, eg, ec;
            run_frame(k == 303 ? 1 : 0);
            ex = (k <= 300) ? 640 - 4 * (k - 161) : (k <= 302) ? 84 : (k == 303) ? 640 : 636;
            es = (k <= 302) ? 1 : 0;
            eg = (k >= 300 && k <= 302) ? 2 : 1;
            ec = (k >= 300 && k <= 302) ? 1 : 0;
            n_vec++;
            if (outs() !== exp_outs(200, ex, es, eg, ec)) begin
                n_err++;
                $display("FAIL collide_frame_%0d: got y=%0d x=%0d s=%0d g=%0d c=%0d, want y=200 x=%0d s=%0d g=%0d c=%0d",
                         k, dino_y, obst_x, score, game_state, collision, ex, es, eg, ec);
            end
        end
    endtask

    // Frames 305..332: airborne press discarded; press coincident with physics acts one frame late.
    task automatic test_jump_edges();
        for (int k = 305; k <= 332; k++) begin
            int ey, mode;
            mode = (k == 305 || k == 306) ? 1 : (k == 331) ? 2 : 0;
            run_frame(mode);
            ey = (k <= 329) ? jump_y[k-305] : (k == 332) ? 188 : 200;
            n_vec++;
            if (outs() !== exp_outs(ey, 640 - 4 * (k - 303), 0, 1, 0)) begin
                n_err++;
                $display("FAIL edge_frame_%0d: got y=%0d x=%0d s=%0d g=%0d c=%0d, want y=%0d x=%0d s=0 g=1 c=0",
                         k, dino_y, obst_x, score, game_state, collision, ey, 640 - 4 * (k - 303));
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); counter_x = 10'd0; counter_y = 10'd480;
        @(negedge clk); counter_x = 10'd1;
        @(negedge clk); counter_x = 10'd2;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({frame_tick, outs()} !== {1'b0, exp_outs(200, 640, 0, 0, 0)}) begin
            n_err++;
            $display("FAIL midseq_reset: got tick=%0d y=%0d x=%0d s=%0d g=%0d c=%0d, want tick=0 y=200 x=640 s=0 g=0 c=0",
                     frame_tick, dino_y, obst_x, score, game_state, collision);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if (outs() !== exp_outs(200, 640, 0, 0, 0)) begin
            n_err++;
            $display("FAIL midseq_no_commit: got y=%0d x=%0d s=%0d g=%0d c=%0d, want y=200 x=640 s=0 g=0 c=0",
                     dino_y, obst_x, score, game_state, collision);
        end
        run_frame(0);
        n_vec++;
        if (outs() !== exp_outs(200, 640, 0, 0, 0) || tick_cycles !== 1) begin
            n_err++;
            $display("FAIL midseq_ready_frame: got y=%0d x=%0d s=%0d g=%0d c=%0d ticks=%0d, want y=200 x=640 s=0 g=0 c=0 ticks=1",
                     dino_y, obst_x, score, game_state, collision, tick_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_scroll();
        test_collision();
        test_jump_edges();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
